ber_checker: RTL and testbench
==============================

BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NB_DATA, 8, width of the signed received sample.
REQ-002 Parameter NB_CNT, 32, width of the bit and error counters.
REQ-003 Parameter OS, 4, oversampling factor (clk cycles per symbol).
REQ-004 Parameter WIN, 64, symbols per lock-monitor window.
REQ-005 Parameter ERR_TH, 8, window error count that declares loss of lock.
REQ-006 Port clk  input  1  single clock, rising edge, at the sample rate (OS x symbol rate).
REQ-007 Port rst  input  1  asynchronous, active-low reset.
REQ-008 Port i_rx  input  NB_DATA  signed two's-complement sample from the tx stage, one per clk.
REQ-009 Port i_phase  input  2  decimation phase, 0..OS-1, selects which sample of each symbol is sliced.
REQ-010 Port i_clear  input  1  synchronous clear of o_bit_cnt and o_err_cnt.
REQ-011 Port o_bit  output  1  last sliced bit.
REQ-012 Port o_lock  output  1  high while the checker is in LOCKED.
REQ-013 Port o_bit_cnt  output  NB_CNT  symbols checked while locked.
REQ-014 Port o_err_cnt  output  NB_CNT  bit errors detected while locked.

Function
REQ-015 A phase counter SHALL count 0..OS-1 (wrapping to 0), starting at 0 on the first clk after reset release; a strobe SHALL be asserted when the counter equals i_phase.
REQ-016 On a strobe, the sliced bit SHALL be 1 when i_rx[NB_DATA-1] is 0 (sample >= 0), else 0; o_bit SHALL update on that edge (1-cycle latency from the sampled i_rx).
REQ-017 The checker SHALL be a self-synchronising PRBS9 checker, polynomial x^9+x^5+1, with a 9-bit shift register sr fed with the received bit on each strobe.
REQ-018 States: LOAD and LOCKED; reset state is LOAD.
REQ-019 LOAD: on each strobe, shift the bit into sr and increment a load counter; after the 9th bit go to LOCKED, unless the 9 bits loaded are all zero, in which case restart LOAD with the load counter at 0.
REQ-020 LOCKED: on each strobe, predicted bit = sr[8] XOR sr[4]; error = predicted XOR received; then shift the received bit into sr.
REQ-021 In LOCKED each strobe SHALL increment o_bit_cnt by 1 and, on error, o_err_cnt by 1; both SHALL saturate at 2^NB_CNT-1 and never wrap.
REQ-022 No counter SHALL change in LOAD.
REQ-023 In LOCKED, a window counter SHALL count strobes 1..WIN and a window error counter SHALL count errors; on the WIN-th strobe, if window errors (including that strobe) >= ERR_TH, go to LOAD with sr and load counter cleared; otherwise clear both window counters and stay LOCKED.
REQ-024 i_clear SHALL zero o_bit_cnt and o_err_cnt on the next edge; if it coincides with a strobe, clear wins and that strobe's increment is dropped; state, sr and window counters are unaffected.
REQ-025 i_phase changes SHALL take effect on the next phase-counter comparison; no glitch strobe beyond one per OS-cycle period is required to be suppressed.
REQ-026 o_lock SHALL be registered and equal to (state == LOCKED).

Reset
REQ-027 rst low SHALL immediately clear the phase counter, sr, load counter, window counters, o_bit, o_lock, o_bit_cnt and o_err_cnt to 0 and force state LOAD, including mid-window.
REQ-028 Reset release SHALL be sampled on clk; the first strobe follows REQ-015.

Configuration
REQ-029 Macro BER_LOCK_LOSS_EN: when defined, REQ-023 window monitoring SHALL be implemented; when undefined, window logic is absent and LOCKED is left only by reset.

Verification
REQ-030 Bits from PRBS9 seed 9'b010101011, each held 4 cycles as i_rx = 0x40 (bit 1) / 0xC0 (bit 0), i_phase = 2 -> o_lock high at the 9th strobe's edge, o_err_cnt = 0, o_bit_cnt = 100 after 100 locked symbols.
REQ-031 Same stream, invert one bit after lock -> o_err_cnt = 3 (self-sync error multiplication), o_lock stays high.
REQ-032 Constant i_rx = 0xC0 (all zeros) for 50 symbols -> o_lock stays 0, counters stay 0.
REQ-033 With BER_LOCK_LOSS_EN, random bits after lock -> o_lock falls at the end of the first window with >= 8 errors; without it, o_lock stays high.
REQ-034 i_clear pulsed on a strobe cycle while locked -> both counters read 0 next cycle, next strobe gives o_bit_cnt = 1.
REQ-035 rst pulsed low mid-window for 3 cycles -> all outputs 0 immediately, relock after 9 further strobes.

Source files
------------

// File: rtl/ber_checker_if.sv
// ----------------------------------------------------------------------------
// ber_checker_if
// Purpose : groups the sample/control inputs and the status/counter outputs
//           of ber_checker into one bundle.
// Signals : i_rx      signed received sample, one per clk
//           i_phase   decimation phase 0..OS-1 (which sample of a symbol)
//           i_clear   synchronous clear of the bit and error counters
//           o_bit     last sliced bit
//           o_lock    high while the checker is locked
//           o_bit_cnt symbols checked while locked (saturating)
//           o_err_cnt bit errors seen while locked (saturating)
// Modports: master drives the inputs (stimulus side), slave is the checker.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ber_checker_if #(
    parameter int NB_DATA = 8,
    parameter int NB_CNT  = 32
);
    logic signed [NB_DATA-1:0] i_rx;
    logic        [1:0]         i_phase;
    logic                      i_clear;
    logic                      o_bit;
    logic                      o_lock;
    logic        [NB_CNT-1:0]  o_bit_cnt;
    logic        [NB_CNT-1:0]  o_err_cnt;

    modport master (
        output i_rx, i_phase, i_clear,
        input  o_bit, o_lock, o_bit_cnt, o_err_cnt
    );

    modport slave (
        input  i_rx, i_phase, i_clear,
        output o_bit, o_lock, o_bit_cnt, o_err_cnt
    );
endinterface

// File: rtl/ber_checker.sv
// ----------------------------------------------------------------------------
// ber_checker
// Purpose : slices an oversampled signed stream to one bit per symbol and
//           checks it against a self-synchronising PRBS9 (x^9 + x^5 + 1).
//           After 9 non-zero bits have been loaded the checker is LOCKED and
//           counts checked symbols and bit errors (both saturating).
// Ports   : clk  sample-rate clock (OS samples per symbol), rising edge
//           rst  asynchronous, active-low reset
//           bus  ber_checker_if.slave: i_rx, i_phase, i_clear in;
//                o_bit, o_lock, o_bit_cnt, o_err_cnt out
// Macro   : BER_LOCK_LOSS_EN -- when defined, a per-window error monitor drops
//           the checker back to LOAD after a bad window; when undefined,
//           LOCKED is only left through reset.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ber_checker #(
    parameter int NB_DATA = 8,
    parameter int NB_CNT  = 32,
    parameter int OS      = 4,
    parameter int WIN     = 64,
    parameter int ERR_TH  = 8
) (
    input logic           clk,
    input logic           rst,
    ber_checker_if.slave  bus
);

    localparam int PW = (OS > 1) ? $clog2(OS) : 1;

    localparam logic [0:0] ST_LOAD   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [NB_CNT-1:0]         CNT_MAX = '1;
    localparam logic signed [NB_DATA-1:0] ZERO    = '0;

    logic [PW-1:0]     phaseCnt_q, phaseCnt_d;
    logic [0:0]        state_q, state_d;
    logic [8:0]        sr_q, sr_d;
    logic [3:0]        loadCnt_q, loadCnt_d;
    logic              bit_q, bit_d;
    logic              lock_q, lock_d;
    logic [NB_CNT-1:0] bitCnt_q, bitCnt_d;
    logic [NB_CNT-1:0] errCnt_q, errCnt_d;

    logic              strobe;
    logic              rxBit;
    logic              predBit;
    logic              bitErr;
    logic [8:0]        srShift;

`ifdef BER_LOCK_LOSS_EN
    localparam int WW = $clog2(WIN + 1);

    logic [WW-1:0] winCnt_q, winCnt_d;
    logic [WW-1:0] winErr_q, winErr_d;
    logic [WW-1:0] winCntInc;
    logic [WW-1:0] winErrInc;
`endif

    // Slicer and PRBS9 predictor. A non-negative sample slices to 1; the
    // signed compare is the same as testing the sign bit.
    always_comb begin
        strobe  = (32'(phaseCnt_q) == 32'(bus.i_phase));
        rxBit   = (bus.i_rx >= ZERO);
        predBit = sr_q[8] ^ sr_q[4];
        bitErr  = predBit ^ rxBit;
        srShift = {sr_q[7:0], rxBit};
    end

    // Next-state logic: LOAD fills the shift register, LOCKED predicts each
    // bit from the previous received bits and counts mismatches.
    always_comb begin
        phaseCnt_d = (32'(phaseCnt_q) == OS - 1) ? '0 : phaseCnt_q + PW'(1);
        state_d    = state_q;
        sr_d       = sr_q;
        loadCnt_d  = loadCnt_q;
        bit_d      = bit_q;
        bitCnt_d   = bitCnt_q;
        errCnt_d   = errCnt_q;
`ifdef BER_LOCK_LOSS_EN
        winCnt_d   = winCnt_q;
        winErr_d   = winErr_q;
        winCntInc  = winCnt_q + WW'(1);
        winErrInc  = winErr_q + WW'(bitErr);
`endif

        if (strobe) begin
            bit_d = rxBit;
            sr_d  = srShift;
            if (state_q == ST_LOAD) begin
                // An all-zero load would lock onto the PRBS dead state,
                // so reload from scratch instead.
                if (loadCnt_q == 4'd8) begin
                    loadCnt_d = 4'd0;
                    if (srShift != 9'd0) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    loadCnt_d = loadCnt_q + 4'd1;
                end
            end else begin
                if (bitCnt_q != CNT_MAX) begin
                    bitCnt_d = bitCnt_q + NB_CNT'(1);
                end
                if (bitErr && (errCnt_q != CNT_MAX)) begin
                    errCnt_d = errCnt_q + NB_CNT'(1);
                end
`ifdef BER_LOCK_LOSS_EN
                if (32'(winCntInc) == WIN) begin
                    winCnt_d = '0;
                    winErr_d = '0;
                    if (32'(winErrInc) >= ERR_TH) begin
                        state_d   = ST_LOAD;
                        sr_d      = '0;
                        loadCnt_d = 4'd0;
                    end
                end else begin
                    winCnt_d = winCntInc;
                    winErr_d = winErrInc;
                end
`endif
            end
        end

        // Clear overrides any increment from a coincident strobe.
        if (bus.i_clear) begin
            bitCnt_d = '0;
            errCnt_d = '0;
        end

        lock_d = (state_d == ST_LOCKED);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phaseCnt_q <= '0;
            state_q    <= ST_LOAD;
            sr_q       <= '0;
            loadCnt_q  <= 4'd0;
            bit_q      <= 1'b0;
            lock_q     <= 1'b0;
            bitCnt_q   <= '0;
            errCnt_q   <= '0;
        end else begin
            phaseCnt_q <= phaseCnt_d;
            state_q    <= state_d;
            sr_q       <= sr_d;
            loadCnt_q  <= loadCnt_d;
            bit_q      <= bit_d;
            lock_q     <= lock_d;
            bitCnt_q   <= bitCnt_d;
            errCnt_q   <= errCnt_d;
        end
    end

`ifdef BER_LOCK_LOSS_EN
    // Window monitor registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winCnt_q <= '0;
            winErr_q <= '0;
        end else begin
            winCnt_q <= winCnt_d;
            winErr_q <= winErr_d;
        end
    end
`endif

    assign bus.o_bit     = bit_q;
    assign bus.o_lock    = lock_q;
    assign bus.o_bit_cnt = bitCnt_q;
    assign bus.o_err_cnt = errCnt_q;

endmodule

// File: tb/tb_ber_checker.sv
`timescale 1ns/1ps

module tb_ber_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [8:0] prbsSr;

    // Generates the clock.
    always #5 clk = ~clk;

    ber_checker_if #(.NB_DATA(8), .NB_CNT(32)) bus ();
    ber_checker_if #(.NB_DATA(8), .NB_CNT(3))  satBus ();

    assign satBus.i_rx    = bus.i_rx;
    assign satBus.i_phase = bus.i_phase;
    assign satBus.i_clear = bus.i_clear;

    ber_checker #(
        .NB_DATA(8), .NB_CNT(32), .OS(4), .WIN(64), .ERR_TH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ber_checker #(
        .NB_DATA(8), .NB_CNT(3), .OS(4), .WIN(64), .ERR_TH(8)
    ) satDut (
        .clk (clk),
        .rst (rst),
        .bus (satBus.slave)
    );

    typedef struct {
        string name;
        int    nSym;
        int    invAt;
        bit    zeros;
        bit    expLock;
        int    expBits;
        int    expErrs;
    } scen_t;

    scen_t tbl [6];

    // Compares one value against its expected value.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advances the reference PRBS9 generator by one bit.
    task automatic nextPrbs(output bit b);
        b      = prbsSr[8] ^ prbsSr[4];
        prbsSr = {prbsSr[7:0], b};
    endtask

    // Holds one symbol for four clocks; optionally pulses i_clear on the strobe clock.
    task automatic applyStimulus(input bit b, input bit clrOnStrobe);
        bus.i_rx = b ? 8'sh40 : 8'shC0;
        for (int c = 0; c < 4; c++) begin
            if (clrOnStrobe && c == 2) bus.i_clear = 1'b1;
            @(posedge clk);
            #1;
            if (clrOnStrobe && c == 2) begin
                bus.i_clear = 1'b0;
                checkOutput("clearBitCnt", bus.o_bit_cnt, 0);
                checkOutput("clearErrCnt", bus.o_err_cnt, 0);
            end
        end
    endtask

    // Holds reset low for a few clocks and releases it just after a rising edge.
    task automatic doReset();
        rst         = 1'b0;
        bus.i_clear = 1'b0;
        bus.i_phase = 2'd2;
        bus.i_rx    = 8'shC0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic longint satVal(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    initial begin
        bit b;
        int expBits;
        int expErrs;

        tbl[0] = '{"prbs100",  109,  -1, 1'b0, 1'b1, 100, 0};
        tbl[1] = '{"invMid",   109,  30, 1'b0, 1'b1, 100, 3};
        tbl[2] = '{"invFirst",  30,   9, 1'b0, 1'b1,  21, 3};
        tbl[3] = '{"invLast",  109, 108, 1'b0, 1'b1, 100, 1};
        tbl[4] = '{"invLoad",   30,   3, 1'b0, 1'b1,  21, 1};
        tbl[5] = '{"zeros50",   50,  -1, 1'b1, 1'b0,   0, 0};

        bus.i_rx    = 8'shC0;
        bus.i_phase = 2'd2;
        bus.i_clear = 1'b0;
        #2;
        checkOutput("rstLock",   bus.o_lock, 0);
        checkOutput("rstBit",    bus.o_bit, 0);
        checkOutput("rstBitCnt", bus.o_bit_cnt, 0);
        checkOutput("rstErrCnt", bus.o_err_cnt, 0);

        for (int s = 0; s < 6; s++) begin
            doReset();
            prbsSr = 9'b010101011;
            for (int k = 0; k < tbl[s].nSym; k++) begin
                if (tbl[s].zeros) b = 1'b0;
                else nextPrbs(b);
                if (k == tbl[s].invAt) b = ~b;
                applyStimulus(b, 1'b0);
            end
            checkOutput({tbl[s].name, "_lock"},   bus.o_lock,      tbl[s].expLock);
            checkOutput({tbl[s].name, "_bits"},   bus.o_bit_cnt,   tbl[s].expBits);
            checkOutput({tbl[s].name, "_errs"},   bus.o_err_cnt,   tbl[s].expErrs);
            checkOutput({tbl[s].name, "_satBits"}, satBus.o_bit_cnt, satVal(tbl[s].expBits));
            checkOutput({tbl[s].name, "_satErrs"}, satBus.o_err_cnt, satVal(tbl[s].expErrs));
        end

        // Lock asserts exactly on the ninth strobe edge, o_bit one edge after the sample.
        doReset();
        prbsSr = 9'b010101011;
        for (int k = 0; k < 8; k++) begin
            nextPrbs(b);
            applyStimulus(b, 1'b0);
        end
        nextPrbs(b);
        bus.i_rx = b ? 8'sh40 : 8'shC0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("lockBeforeStrobe9", bus.o_lock, 0);
        @(posedge clk);
        #1;
        checkOutput("lockAtStrobe9", bus.o_lock, 1);
        checkOutput("bitAtStrobe9",  bus.o_bit, b);
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            nextPrbs(b);
            applyStimulus(b, 1'b0);
        end
        checkOutput("lockedBits20", bus.o_bit_cnt, 20);
        checkOutput("lockedErrs20", bus.o_err_cnt, 0);

        // Clear coinciding with a strobe drops that increment.
        nextPrbs(b);
        applyStimulus(b, 1'b1);
        nextPrbs(b);
        applyStimulus(b, 1'b0);
        checkOutput("afterClearBits", bus.o_bit_cnt, 1);
        checkOutput("afterClearErrs", bus.o_err_cnt, 0);
        checkOutput("afterClearLock", bus.o_lock, 1);

        // Asynchronous reset mid-window, then relock after nine strobes.
        for (int k = 0; k < 5; k++) begin
            nextPrbs(b);
            applyStimulus(b, 1'b0);
        end
        rst = 1'b0;
        #1;
        checkOutput("asyncRstLock",   bus.o_lock, 0);
        checkOutput("asyncRstBit",    bus.o_bit, 0);
        checkOutput("asyncRstBitCnt", bus.o_bit_cnt, 0);
        checkOutput("asyncRstErrCnt", bus.o_err_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            nextPrbs(b);
            applyStimulus(b, 1'b0);
        end
        checkOutput("relockAfter8", bus.o_lock, 0);
        nextPrbs(b);
        applyStimulus(b, 1'b0);
        checkOutput("relockAfter9", bus.o_lock, 1);
        for (int k = 0; k < 10; k++) begin
            nextPrbs(b);
            applyStimulus(b, 1'b0);
        end
        checkOutput("relockBits", bus.o_bit_cnt, 10);
        checkOutput("relockErrs", bus.o_err_cnt, 0);

        // Constant ones after lock: every locked strobe is an error.
        doReset();
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0);
        checkOutput("onesLock", bus.o_lock, 1);
        for (int k = 0; k < 63; k++) applyStimulus(1'b1, 1'b0);
        checkOutput("ones63Lock", bus.o_lock, 1);
        checkOutput("ones63Bits", bus.o_bit_cnt, 63);
        checkOutput("ones63Errs", bus.o_err_cnt, 63);
        checkOutput("satBitsMax", satBus.o_bit_cnt, 7);
        checkOutput("satErrsMax", satBus.o_err_cnt, 7);
        applyStimulus(1'b1, 1'b0);
`ifdef BER_LOCK_LOSS_EN
        checkOutput("windowEndLock", bus.o_lock, 0);
`else
        checkOutput("windowEndLock", bus.o_lock, 1);
`endif
        checkOutput("ones64Bits", bus.o_bit_cnt, 64);
        checkOutput("ones64Errs", bus.o_err_cnt, 64);
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0);
`ifdef BER_LOCK_LOSS_EN
        expBits = 64;
        expErrs = 64;
`else
        expBits = 73;
        expErrs = 73;
`endif
        checkOutput("ones73Lock", bus.o_lock, 1);
        checkOutput("ones73Bits", bus.o_bit_cnt, expBits);
        checkOutput("ones73Errs", bus.o_err_cnt, expErrs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
